multi_clock_prescaler: RTL and testbench
========================================

MULTI_CLOCK_PRESCALER -- requirements
Module: multi_clock_prescaler

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 25, divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 2000000, reset divisor for every channel; DEF_DIV SHALL be greater than or equal to 1 and less than 2^CNT_W.
REQ-004 CLK100MHZ  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 CPU_RESETN  input  1  reset; synchronous, active-low.
REQ-006 ch_en  input  NUM_CH  per-channel run enable.
REQ-007 cfg_valid  input  1  divisor-load request.
REQ-008 cfg_ch  input  clog2(NUM_CH), minimum 1  target channel of the load.
REQ-009 cfg_div  input  CNT_W  new divisor value.
REQ-010 cfg_ready  output  1  load accepted when cfg_valid and cfg_ready are both high in the same cycle.
REQ-011 tick  output  NUM_CH  one-cycle pulse per channel at terminal count.
REQ-012 clk_out  output  NUM_CH  per-channel divided square wave, registered.

Function
REQ-013 Each enabled channel SHALL count cnt from 0 to div-1; at div-1, cnt returns to 0, the channel's tick is high for exactly that cycle, and its clk_out toggles on the next edge.
REQ-014 clk_out period SHALL be 2*div cycles with 50% duty cycle; tick period SHALL be div cycles.
REQ-015 div = 1 SHALL assert tick every cycle and toggle clk_out every cycle.
REQ-016 A cfg_div of 0 SHALL be accepted and stored as 1.
REQ-017 Each channel SHALL hold one pending divisor plus a pending flag.
REQ-018 cfg_ready SHALL be the inverse of the pending flag of the channel addressed by cfg_ch (combinational).
REQ-019 cfg_ch values of NUM_CH or above SHALL be accepted and discarded.
REQ-020 On an enabled channel, a pending divisor SHALL be applied on the edge following that channel's terminal count, so no shortened or stretched half-period occurs.
REQ-021 On a disabled channel, a pending divisor SHALL be applied on the next edge.
REQ-022 A load accepted in the same cycle as that channel's terminal count SHALL wait for the following terminal count.
REQ-023 ch_en low SHALL force cnt to 0, tick to 0 and clk_out to 0 on the next edge; a pending load is kept.
REQ-024 A 0-to-1 transition of ch_en SHALL restart the channel from cnt 0, with its first tick div cycles later.
REQ-025 Channels SHALL be fully independent; simultaneous terminal counts on any subset SHALL all be honoured.

Reset
REQ-026 With CPU_RESETN low at an edge, every channel SHALL set cnt=0, div=DEF_DIV, pending flag=0, tick=0, clk_out=0; cfg_ready SHALL then be 1.
REQ-027 Reset SHALL take priority over ch_en, cfg_valid and sync; reset in mid-count SHALL discard the count and any pending load.

Configuration
REQ-028 Macro PRESCALER_SYNC_EN SHALL add input port sync_i (1 bit).
REQ-029 With PRESCALER_SYNC_EN defined, sync_i high SHALL, on the next edge, set every enabled channel to cnt=0 and clk_out=0, apply any pending divisor, and suppress tick that cycle.
REQ-030 sync_i SHALL take priority over a coincident terminal count.
REQ-031 Without PRESCALER_SYNC_EN, sync_i SHALL be absent and the behaviour SHALL be exactly REQ-013 to REQ-027.

Structure
REQ-032 Package clk_prescaler_pkg SHALL hold the DEF_CNT_W and DEF_DIV constants and typedef div_t (logic [CNT_W-1:0]).
REQ-033 Sub-module prescaler_channel SHALL implement one counter, divisor, pending flag, tick and clk_out, instantiated NUM_CH times by generate.

Verification
REQ-034 Reset, then ch_en=4'b0001 with DEF_DIV overridden to 5 -> tick[0] every 5 cycles, clk_out[0] period 10 cycles, other channels 0.
REQ-035 Load cfg_ch=1, cfg_div=3 while channel 1 runs at div 5 -> cfg_ready[1] low until the terminal count, then period becomes 6 with no short half-period.
REQ-036 cfg_div=0 to channel 2 -> tick[2] asserted every cycle, clk_out[2] toggles every cycle.
REQ-037 Drop ch_en[0] mid-count at cnt=2, re-raise 3 cycles later -> clk_out[0]=0 while disabled; first tick 5 cycles after re-enable.
REQ-038 CPU_RESETN low at cnt=3 with a load pending -> all outputs 0, div back to DEF_DIV, cfg_ready=1 next cycle.
REQ-039 With PRESCALER_SYNC_EN: channels at div 4 and 6, sync_i pulse -> both clk_out 0 and both count from 0; their ticks coincide 12 cycles later.

Source files
------------

// File: rtl/clk_prescaler_pkg.sv
// clk_prescaler_pkg: shared constants, divisor type and sizing helper for the clock prescaler
package clk_prescaler_pkg;
    localparam int DEF_CNT_W = 25;
    localparam int DEF_DIV = 2000000;
    typedef logic [DEF_CNT_W-1:0] div_t;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prescaler_channel.sv
// prescaler_channel: one divider channel with live and pending divisor, tick pulse and square-wave output
module prescaler_channel import clk_prescaler_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEF_DIV = clk_prescaler_pkg::DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             pend,
    output logic             tick,
    output logic             clk_out
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic             tc;

    assign tc = en && (cnt == div - CNT_W'(1));

    // count, swap in the pending divisor only at a period boundary, drive tick and clk_out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            div      <= CNT_W'(DEF_DIV);
            pend_div <= CNT_W'(DEF_DIV);
            pend     <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            if (load) begin
                pend     <= 1'b1;
                pend_div <= (load_div == '0) ? CNT_W'(1) : load_div;
            end
            if (pend && (!en || sync || tc)) begin
                div  <= pend_div;
                pend <= 1'b0;
            end
            if (!en || sync) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
            end else begin
                cnt     <= tc ? '0 : cnt + CNT_W'(1);
                tick    <= tc;
                clk_out <= clk_out ^ tc;
            end
        end
    end
endmodule

// File: rtl/multi_clock_prescaler.sv
// multi_clock_prescaler: NUM_CH independent clock dividers with a shared divisor-load port; define PRESCALER_SYNC_EN to add the sync_i restart input
module multi_clock_prescaler import clk_prescaler_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEF_DIV = clk_prescaler_pkg::DEF_DIV,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
`ifdef PRESCALER_SYNC_EN
    input  logic              sync_i,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);
    logic [NUM_CH-1:0] pend;
    logic              sync;

`ifdef PRESCALER_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // ready follows the addressed channel's pending slot; addresses with no channel always accept and drop
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        prescaler_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (CLK100MHZ),
            .rst_n    (CPU_RESETN),
            .en       (ch_en[c]),
            .sync     (sync),
            .load     (cfg_valid && cfg_ready && (cfg_ch == CH_W'(c))),
            .load_div (cfg_div),
            .pend     (pend[c]),
            .tick     (tick[c]),
            .clk_out  (clk_out[c])
        );
    end
endmodule

// File: tb/tb_multi_clock_prescaler.sv
// tb_multi_clock_prescaler: scoreboard bench for the prescaler with DEF_DIV overridden to 5
module tb_multi_clock_prescaler;
    localparam int NCH = 4;
    localparam int CW = 25;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] clk_out;
        logic           ready;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic           cfg_valid = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_ready;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
`ifdef PRESCALER_SYNC_EN
    logic           sync_i = 1'b0;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    multi_clock_prescaler #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(5)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rstn),
`ifdef PRESCALER_SYNC_EN
        .sync_i     (sync_i),
`endif
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .tick       (tick),
        .clk_out    (clk_out)
    );

    always #5 clk = ~clk;

    function automatic logic tick_at(input int j, input int d);
        return ((j + 1) % d) == 0;
    endfunction

    function automatic logic co_at(input int j, input int d);
        return (((j + 1) / d) % 2) != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NCH-1:0] en);
        rstn = 1'b0;
        ch_en = '0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
`ifdef PRESCALER_SYNC_EN
        sync_i = 1'b0;
`endif
        step();
        step();
        rstn = 1'b1;
        ch_en = en;
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0;
        ch_en = 4'b1111;
        cfg_valid = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = CW'(7);
        for (int j = 0; j < 3; j++) begin
            sb.push_back({4'b0, 4'b0, 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL reset j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        do_reset(4'b0001);
        for (int j = 0; j < 22; j++) begin
            sb.push_back({3'b0, tick_at(j, 5), 3'b0, co_at(j, 5), 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL basic j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
    endtask

    task automatic test_reload();
        exp_t e;
        logic t, c, r;
        do_reset(4'b0010);
        cfg_ch = 2'd1;
        for (int j = 0; j < 24; j++) begin
            cfg_valid = (j == 2) || (j == 7);
            cfg_div = (j < 5) ? CW'(3) : CW'(4);
            if (j <= 4) begin
                t = tick_at(j, 5);
                c = co_at(j, 5);
            end else if (j <= 10) begin
                t = tick_at(j - 5, 3);
                c = ~co_at(j - 5, 3);
            end else begin
                t = tick_at(j - 11, 4);
                c = ~co_at(j - 11, 4);
            end
            r = !((j >= 2 && j <= 3) || (j >= 7 && j <= 9));
            sb.push_back({2'b0, t, 1'b0, 2'b0, c, 1'b0, r});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL reload j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_div_zero();
        exp_t e;
        do_reset(4'b0000);
        cfg_ch = 2'd2;
        cfg_div = '0;
        for (int j = 0; j < 10; j++) begin
            cfg_valid = (j == 0);
            ch_en = (j >= 2) ? 4'b0100 : 4'b0000;
            if (j < 2) sb.push_back({4'b0, 4'b0, (j == 1)});
            else sb.push_back({4'b0100, 1'b0, (j % 2) == 0, 2'b0, 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL div_zero j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
    endtask

    task automatic test_enable_toggle();
        exp_t e;
        int k;
        do_reset(4'b0001);
        for (int j = 0; j < 22; j++) begin
            ch_en = (j >= 7 && j <= 9) ? 4'b0000 : 4'b0001;
            k = j - 10;
            if (j < 7) sb.push_back({3'b0, tick_at(j, 5), 3'b0, co_at(j, 5), 1'b1});
            else if (j <= 9) sb.push_back({4'b0, 4'b0, 1'b1});
            else sb.push_back({3'b0, tick_at(k, 5), 3'b0, co_at(k, 5), 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL enable j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
    endtask

    task automatic test_reset_midcount();
        exp_t e;
        int k;
        do_reset(4'b0010);
        cfg_ch = 2'd1;
        cfg_div = CW'(3);
        for (int j = 0; j < 19; j++) begin
            cfg_valid = (j == 1);
            rstn = (j != 3);
            k = j - 4;
            if (j < 3) sb.push_back({2'b0, tick_at(j, 5), 1'b0, 2'b0, co_at(j, 5), 1'b0, (j == 0)});
            else if (j == 3) sb.push_back({4'b0, 4'b0, 1'b1});
            else sb.push_back({2'b0, tick_at(k, 5), 1'b0, 2'b0, co_at(k, 5), 1'b0, 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL reset_mid j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int dv[NCH] = '{2, 3, 4, 6};
        logic [NCH-1:0] t, c;
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) begin
            cfg_valid = (i < 4);
            cfg_ch = (i < 4) ? 2'(i) : 2'd3;
            cfg_div = (i < 4) ? CW'(dv[i]) : '0;
            sb.push_back({4'b0, 4'b0, (i == 4)});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL b2b_load i=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", i, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
        ch_en = 4'b1111;
        for (int j = 0; j < 24; j++) begin
            for (int n = 0; n < NCH; n++) begin
                t[n] = tick_at(j, dv[n]);
                c[n] = co_at(j, dv[n]);
            end
            sb.push_back({t, c, 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL b2b_run j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
    endtask

`ifdef PRESCALER_SYNC_EN
    task automatic test_sync();
        exp_t e;
        int k;
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) begin
            cfg_valid = (i < 2);
            cfg_ch = (i == 0) ? 2'd0 : 2'd1;
            cfg_div = (i == 0) ? CW'(4) : CW'(6);
            step();
        end
        ch_en = 4'b0011;
        for (int j = 0; j < 21; j++) begin
            sync_i = (j == 7);
            k = j - 8;
            if (j < 7) sb.push_back({2'b0, tick_at(j, 6), tick_at(j, 4), 2'b0, co_at(j, 6), co_at(j, 4), 1'b1});
            else if (j == 7) sb.push_back({4'b0, 4'b0, 1'b1});
            else sb.push_back({2'b0, tick_at(k, 6), tick_at(k, 4), 2'b0, co_at(k, 6), co_at(k, 4), 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (exp_t'({tick, clk_out, cfg_ready}) !== e)
                $display("FAIL sync j=%0d got tick=%b clk=%b rdy=%b want tick=%b clk=%b rdy=%b", j, tick, clk_out, cfg_ready, e.tick, e.clk_out, e.ready);
            else passes++;
        end
        sync_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_div_zero();
        test_enable_toggle();
        test_reset_midcount();
        test_back_to_back();
`ifdef PRESCALER_SYNC_EN
        test_sync();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
